// File: rtl/otter_mmio_pkg.sv
// Shared constants for the OTTER MMIO UART: register offsets, STATUS/CTRL bit
// positions and the serialiser state encoding.
package otter_mmio_pkg;

   localparam logic [3:0] DATA_OFS   = 4'h0;
   localparam logic [3:0] STATUS_OFS = 4'h4;
   localparam logic [3:0] CTRL_OFS   = 4'h8;

   localparam int ST_FULL    = 0;
   localparam int ST_EMPTY   = 1;
   localparam int ST_BUSY    = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_CNT_LSB = 8;

   localparam int CTRL_TX_EN  = 0;
   localparam int CTRL_IRQ_EN = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

endpackage

// File: rtl/otter_mmio_uart_if.sv
// OTTER data-memory I/O port as seen by a memory-mapped peripheral.
interface otter_mmio_uart_if;
   logic [31:0] IO_ADDR;
   logic        IO_WR;
   logic [31:0] IO_DIN;
   logic [31:0] IO_DOUT;

   modport master (output IO_ADDR, output IO_WR, output IO_DIN, input IO_DOUT);
   modport slave  (input IO_ADDR, input IO_WR, input IO_DIN, output IO_DOUT);
endinterface

// File: rtl/otter_sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only when a pop frees the
// slot in the same cycle.
module otter_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_din,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_dout,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CNT_MAX);
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_dout    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_ONE;
         else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_ONE;
      end
   end

   // NOTE: storage has no reset; the pointers and count alone define validity.
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_din;
   end

endmodule

// File: rtl/otter_mmio_uart.sv
// Memory-mapped 8N1 UART transmitter for the OTTER I/O port with a TX FIFO.
// Optional interrupt output enabled by defining OTTER_UART_IRQ_EN.
module otter_mmio_uart
   import otter_mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h1100_0040,
   parameter int          BAUD_DIV   = 868,
   parameter int          FIFO_DEPTH = 16
) (
   input  logic                  IO_CLK,
   input  logic                  IO_RST_N,
   otter_mmio_uart_if.slave      io_bus,
`ifdef OTTER_UART_IRQ_EN
   output logic                  UART_IRQ,
`endif
   output logic                  UART_TX
);

   localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);

   logic          w_hit;
   logic [3:0]    w_ofs;
   logic          w_wr_data;
   logic          w_wr_status;
   logic          w_wr_ctrl;
   logic          w_full;
   logic          w_empty;
   logic [CW-1:0] w_count;
   logic [7:0]    w_fifo_dout;
   logic          w_pop;
   logic          w_irq_en;
   logic          w_unused_bits;

   logic          r_tx_en;
   logic          r_ovf;
   uart_state_t   r_state;
   logic [15:0]   r_baud;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_tx;

   uart_state_t   w_state_nxt;
   logic [15:0]   w_baud_nxt;
   logic [2:0]    w_bit_nxt;
   logic [7:0]    w_shift_nxt;
   logic          w_can_pop;
   logic          w_baud_done;
   logic [31:0]   w_status;

   assign w_hit         = (io_bus.IO_ADDR[31:4] == BASE_ADDR[31:4]);
   assign w_ofs         = {io_bus.IO_ADDR[3:2], 2'b00};
   assign w_wr_data     = io_bus.IO_WR & w_hit & (w_ofs == DATA_OFS);
   assign w_wr_status   = io_bus.IO_WR & w_hit & (w_ofs == STATUS_OFS);
   assign w_wr_ctrl     = io_bus.IO_WR & w_hit & (w_ofs == CTRL_OFS);
   assign w_unused_bits = ^{io_bus.IO_ADDR[1:0], io_bus.IO_DIN[31:8]};

   otter_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk   (IO_CLK),
      .i_rst_n (IO_RST_N),
      .i_push  (w_wr_data),
      .i_din   (io_bus.IO_DIN[7:0]),
      .i_pop   (w_pop),
      .o_dout  (w_fifo_dout),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
      if (!IO_RST_N) begin
         r_tx_en <= 1'b1;
         r_ovf   <= 1'b0;
      end else begin
         if (w_wr_ctrl) r_tx_en <= io_bus.IO_DIN[CTRL_TX_EN];
         if (w_wr_status && io_bus.IO_DIN[ST_OVF]) r_ovf <= 1'b0;
         if (w_wr_data && w_full && !w_pop)        r_ovf <= 1'b1;
      end
   end

`ifdef OTTER_UART_IRQ_EN
   logic r_irq_en;
   logic r_irq;

   always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
      if (!IO_RST_N) begin
         r_irq_en <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         if (w_wr_ctrl) r_irq_en <= io_bus.IO_DIN[CTRL_IRQ_EN];
         r_irq <= r_irq_en & w_empty & (r_state == IDLE);
      end
   end

   assign w_irq_en = r_irq_en;
   assign UART_IRQ = r_irq;
`else
   assign w_irq_en = 1'b0;
`endif

   assign w_can_pop   = r_tx_en & ~w_empty;
   assign w_baud_done = (r_baud == 16'd0);

   // NOTE: every output gets a default first so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_pop       = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_can_pop) begin
               w_pop       = 1'b1;
               w_state_nxt = START;
               w_shift_nxt = w_fifo_dout;
               w_baud_nxt  = BAUD_RELOAD;
            end
         end
         START: begin
            if (w_baud_done) begin
               w_state_nxt = DATA;
               w_baud_nxt  = BAUD_RELOAD;
               w_bit_nxt   = 3'd0;
            end else begin
               w_baud_nxt = r_baud - 16'd1;
            end
         end
         DATA: begin
            if (w_baud_done) begin
               w_baud_nxt = BAUD_RELOAD;
               if (r_bit == 3'd7) begin
                  w_state_nxt = STOP;
               end else begin
                  w_bit_nxt   = r_bit + 3'd1;
                  w_shift_nxt = {1'b0, r_shift[7:1]};
               end
            end else begin
               w_baud_nxt = r_baud - 16'd1;
            end
         end
         STOP: begin
            if (w_baud_done) begin
               if (w_can_pop) begin
                  w_pop       = 1'b1;
                  w_state_nxt = START;
                  w_shift_nxt = w_fifo_dout;
                  w_baud_nxt  = BAUD_RELOAD;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else begin
               w_baud_nxt = r_baud - 16'd1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // The line level is registered from the next state so it moves on the same
   // edge as the state, with no extra cycle of latency.
   always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
      if (!IO_RST_N) begin
         r_state <= IDLE;
         r_baud  <= 16'd0;
         r_bit   <= 3'd0;
         r_shift <= 8'd0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_tx    <= (w_state_nxt == START) ? 1'b0 :
                    (w_state_nxt == DATA)  ? w_shift_nxt[0] : 1'b1;
      end
   end

   assign UART_TX = r_tx;

   always_comb begin
      w_status                       = '0;
      w_status[ST_FULL]              = w_full;
      w_status[ST_EMPTY]             = w_empty;
      w_status[ST_BUSY]              = (r_state != IDLE);
      w_status[ST_OVF]               = r_ovf;
      w_status[ST_CNT_LSB +: CW]     = w_count;
      io_bus.IO_DOUT                 = '0;
      if (w_hit) begin
         case (w_ofs)
            STATUS_OFS: io_bus.IO_DOUT = w_status;
            CTRL_OFS:   io_bus.IO_DOUT = {30'd0, w_irq_en, r_tx_en};
            default:    io_bus.IO_DOUT = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_otter_mmio_uart.sv
// Directed bench for otter_mmio_uart at BAUD_DIV=4, FIFO_DEPTH=4; inputs change
// and outputs are sampled on the falling clock edge.
module tb_otter_mmio_uart;

   localparam logic [31:0] BASE = 32'h1100_0040;
   localparam logic [31:0] A_DATA   = BASE;
   localparam logic [31:0] A_STATUS = BASE + 32'h4;
   localparam logic [31:0] A_CTRL   = BASE + 32'h8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic tx;
   logic irq;
   int   n_total = 0;
   int   n_bad   = 0;

   otter_mmio_uart_if bus ();

   otter_mmio_uart #(
      .BASE_ADDR  (BASE),
      .BAUD_DIV   (4),
      .FIFO_DEPTH (4)
   ) dut (
      .IO_CLK   (clk),
      .IO_RST_N (rst_n),
      .io_bus   (bus),
`ifdef OTTER_UART_IRQ_EN
      .UART_IRQ (irq),
`endif
      .UART_TX  (tx)
   );

`ifndef OTTER_UART_IRQ_EN
   assign irq = 1'b0;
`endif

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.IO_ADDR = a;
      bus.IO_DIN  = d;
      bus.IO_WR   = 1'b1;
      @(negedge clk);
      bus.IO_WR   = 1'b0;
   endtask

   task automatic check_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      bus.IO_ADDR = a;
      #1;
      check(tag, bus.IO_DOUT, exp);
   endtask

   task automatic watch_low(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) cnt++;
      end
   endtask

   // Starts on the first start-bit sample; ends on the sample after the stop bit.
   task automatic check_frame(input string tag, input logic [7:0] b);
      logic [9:0] got;
      logic [9:0] exp;
      logic [3:0] s;
      int         unstable;
      exp      = {1'b1, b, 1'b0};
      got      = '0;
      unstable = 0;
      for (int k = 0; k < 10; k++) begin
         for (int j = 0; j < 4; j++) begin
            s[j] = tx;
            @(negedge clk);
         end
         got[k] = s[1];
         if (s != {4{s[0]}}) unstable++;
      end
      check({tag, "_bits"}, {22'd0, got}, {22'd0, exp});
      check({tag, "_stable"}, unstable, 0);
   endtask

   task automatic wait_start(input string tag);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (tx === 1'b0) found = 1'b1;
         else @(negedge clk);
      end
      check(tag, {31'd0, found}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;
      bus.IO_ADDR = '0;
      bus.IO_WR   = 1'b0;
      bus.IO_DIN  = '0;

      // Reset state and register map
      repeat (3) @(negedge clk);
      check("tx_in_reset", {31'd0, tx}, 32'd1);
      rst_n = 1'b1;
      @(negedge clk);
      check_rd("status_reset", A_STATUS, 32'h0000_0002);
      check_rd("ctrl_reset", A_CTRL, 32'h0000_0001);
      check_rd("data_reads0", A_DATA, 32'h0);
      check_rd("reserved_reads0", BASE + 32'hC, 32'h0);
      check_rd("miss_dout0", BASE + 32'h10, 32'h0);
      check_rd("addr_lsb_ignored", BASE + 32'h7, 32'h0000_0002);
      check("irq_reset", {31'd0, irq}, 32'd0);
      watch_low(8, cnt);
      check("idle_after_reset", cnt, 0);
      wr(A_CTRL, 32'h3);
`ifdef OTTER_UART_IRQ_EN
      check_rd("ctrl_rw", A_CTRL, 32'h0000_0003);
`else
      check_rd("ctrl_rw", A_CTRL, 32'h0000_0001);
`endif
      wr(A_CTRL, 32'h1);
      @(negedge clk);

      // Single frame 0xA5, then idle
      wr(A_DATA, 32'h0000_00A5);
      @(negedge clk);
      check_frame("frame_a5", 8'hA5);
      check_rd("status_after_a5", A_STATUS, 32'h0000_0002);
      check("tx_idle_after_a5", {31'd0, tx}, 32'd1);

      // Store that misses the block
      wr(BASE + 32'h10, 32'h0000_0055);
      check_rd("status_after_miss", A_STATUS, 32'h0000_0002);
      watch_low(10, cnt);
      check("miss_no_frame", cnt, 0);

      // Burst of six stores: one in flight, four queued, one dropped
      fork
         begin
            for (int i = 0; i < 6; i++) wr(A_DATA, 32'h11 + i);
            check_rd("status_overflow", A_STATUS, 32'h0000_040D);
            wr(A_STATUS, 32'h8);
            check_rd("status_ovf_cleared", A_STATUS, 32'h0000_0405);
         end
         begin
            wait_start("burst_start");
            for (int i = 0; i < 5; i++) check_frame($sformatf("burst_%0d", i), 8'h11 + 8'(i));
         end
      join
      check_rd("status_after_burst", A_STATUS, 32'h0000_0002);

      // tx_en cleared mid-frame with two bytes queued
      wr(A_DATA, 32'h3C);
      wr(A_DATA, 32'h5A);
      wr(A_DATA, 32'h96);
      wr(A_CTRL, 32'h0);
      check_rd("paused_busy", A_STATUS, 32'h0000_0204);
      repeat (37) @(negedge clk);
      check_rd("paused_last_stop", A_STATUS, 32'h0000_0204);
      @(negedge clk);
      check_rd("paused_idle", A_STATUS, 32'h0000_0200);
      watch_low(20, cnt);
      check("paused_line_idle", cnt, 0);
      check_rd("paused_count_kept", A_STATUS, 32'h0000_0200);
      wr(A_CTRL, 32'h1);
      @(negedge clk);
      check_frame("resume_5a", 8'h5A);
      check_frame("resume_96", 8'h96);
      check_rd("status_after_resume", A_STATUS, 32'h0000_0002);

      // Reset in the middle of the data bits
      wr(A_DATA, 32'h00);
      wr(A_DATA, 32'h77);
      repeat (10) @(negedge clk);
      check("mid_data_low", {31'd0, tx}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("tx_async_reset", {31'd0, tx}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      check_rd("status_after_rst", A_STATUS, 32'h0000_0002);
      watch_low(60, cnt);
      check("no_residual_frame", cnt, 0);
      check_rd("status_after_rst_idle", A_STATUS, 32'h0000_0002);

`ifdef OTTER_UART_IRQ_EN
      // Interrupt on drain, cleared by a push and by clearing irq_en
      wr(A_CTRL, 32'h3);
      wr(A_DATA, 32'h81);
      @(negedge clk);
      check_frame("irq_frame_81", 8'h81);
      check("irq_low_at_stop_end", {31'd0, irq}, 32'd0);
      @(negedge clk);
      check("irq_rise", {31'd0, irq}, 32'd1);
      wr(A_DATA, 32'h42);
      check("irq_held_on_push_edge", {31'd0, irq}, 32'd1);
      @(negedge clk);
      check("irq_drop_after_push", {31'd0, irq}, 32'd0);
      check_frame("irq_frame_42", 8'h42);
      @(negedge clk);
      check("irq_rise_again", {31'd0, irq}, 32'd1);
      wr(A_CTRL, 32'h1);
      check("irq_held_on_ctrl_edge", {31'd0, irq}, 32'd1);
      @(negedge clk);
      check("irq_drop_after_disable", {31'd0, irq}, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
